ram_march_tester: RTL and testbench

//  Avalon-MM master built-in self-test for the on-chip 32-bit single-port RAM; drives its s1 slave port directly.
//  Two-pass test: write pattern to every word, read back and compare, then repeat with the inverted pattern.

---
 rtl/ram_march_tester_pkg.sv | 23 ++
 rtl/ram_bist_cmp_pipe.sv | 54 +++++
 rtl/ram_march_tester.sv | 187 ++++++++++++++++++
 tb/tb_ram_march_tester.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_march_tester_pkg.sv
// Shared types for the RAM march BIST: FSM states and the test pattern.
// The pattern helper works at a wide fixed width; callers truncate.
package ram_march_tester_pkg;

  localparam int PAT_MAX_W = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_DRAIN,
    ST_FIN
  } state_e;

  function automatic logic [PAT_MAX_W-1:0] pattern(
    input logic [PAT_MAX_W-1:0] seed,
    input logic [PAT_MAX_W-1:0] addr,
    input logic                 k
  );
    return (seed ^ addr) ^ {PAT_MAX_W{k}};
  endfunction

endpackage

// File: rtl/ram_bist_cmp_pipe.sv
// Expected-data/address shift pipe aligned to the RAM read latency,
// with the readdata comparator at its output.
module ram_bist_cmp_pipe #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_exp,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_mismatch,
  output logic [ADDR_W-1:0] o_addr
);

  logic [RD_LATENCY-1:0] r_vld;
  logic [DATA_W-1:0]     r_exp [RD_LATENCY];
  logic [ADDR_W-1:0]     r_adr [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (!reset_n || i_flush) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_push;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_exp[i] <= '0;
        r_adr[i] <= '0;
      end
    end else begin
      r_exp[0] <= i_exp;
      r_adr[0] <= i_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_exp[i] <= r_exp[i-1];
        r_adr[i] <= r_adr[i-1];
      end
    end
  end

  assign o_mismatch = r_vld[RD_LATENCY-1] &&
                      (i_rdata != r_exp[RD_LATENCY-1]);
  assign o_addr     = r_adr[RD_LATENCY-1];

endmodule

// File: rtl/ram_march_tester.sv
// Two-pass write/read-compare BIST master for a single-port on-chip RAM.
// Bus outputs decode directly from state and address registers.
module ram_march_tester
  import ram_march_tester_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 8192,
  parameter int RD_LATENCY = 1,
  parameter int ERR_W      = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   first_fail_addr,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic                m_clken,
  input  logic [DATA_W-1:0]   m_readdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        DRN_LAST  = 2'(RD_LATENCY - 1);

  state_e            r_state;
  state_e            w_state_nx;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nx;
  logic [1:0]        r_dcnt;
  logic [1:0]        w_dcnt_nx;
  logic              r_k;
  logic              w_k_nx;
  logic [DATA_W-1:0] r_seed;
  logic              r_done;
  logic              r_pass;
  logic [ERR_W-1:0]  r_err;
  logic [ADDR_W-1:0] r_ffa;

  logic              w_start;
  logic              w_abort;
  logic              w_wr;
  logic              w_rd;
  logic              w_fin;
  logic              w_mis;
  logic [ADDR_W-1:0] w_mis_addr;
  logic [DATA_W-1:0] w_pat;

  assign w_start = start && (r_state == ST_IDLE);
  assign w_abort = abort && (r_state != ST_IDLE);
  assign w_wr    = (r_state == ST_WR);
  assign w_rd    = (r_state == ST_RD);
  assign w_fin   = (r_state == ST_FIN);
  assign w_pat   = DATA_W'(pattern(PAT_MAX_W'(r_seed),
                                   PAT_MAX_W'(r_addr), r_k));

  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_dcnt_nx  = r_dcnt;
    w_k_nx     = r_k;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nx = ST_WR;
          w_addr_nx  = '0;
          w_k_nx     = 1'b0;
        end
      end
      ST_WR: begin
        if (r_addr == LAST_ADDR) begin
          w_state_nx = ST_RD;
          w_addr_nx  = '0;
        end else begin
          w_addr_nx = r_addr + ADDR_W'(1);
        end
      end
      ST_RD: begin
        if (r_addr == LAST_ADDR) begin
          w_state_nx = ST_DRAIN;
          w_addr_nx  = '0;
          w_dcnt_nx  = '0;
        end else begin
          w_addr_nx = r_addr + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (r_dcnt == DRN_LAST) begin
          if (r_k) begin
            w_state_nx = ST_FIN;
          end else begin
            w_state_nx = ST_WR;
            w_k_nx     = 1'b1;
          end
        end else begin
          w_dcnt_nx = r_dcnt + 2'd1;
        end
      end
      ST_FIN:  w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
    if (w_abort) begin
      w_state_nx = ST_IDLE;
      w_addr_nx  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_dcnt  <= '0;
      r_k     <= 1'b0;
      r_seed  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_dcnt  <= w_dcnt_nx;
      r_k     <= w_k_nx;
      if (w_start) r_seed <= seed;
    end
  end

  // An abort edge freezes the status: any compare landing on it is dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_err  <= '0;
      r_ffa  <= '0;
    end else if (w_start) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_err  <= '0;
      r_ffa  <= '0;
    end else if (w_abort) begin
      r_done <= 1'b1;
      r_pass <= 1'b0;
    end else begin
      if (w_mis) begin
        if (r_err != '1) r_err <= r_err + ERR_W'(1);
        if (r_err == '0) r_ffa <= w_mis_addr;
      end
      if (w_fin) begin
        r_done <= 1'b1;
        r_pass <= (r_err == '0);
      end
    end
  end

  ram_bist_cmp_pipe #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RD_LATENCY(RD_LATENCY)
  ) u_cmp (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_flush   (w_abort),
    .i_push    (w_rd),
    .i_exp     (w_pat),
    .i_addr    (r_addr),
    .i_rdata   (m_readdata),
    .o_mismatch(w_mis),
    .o_addr    (w_mis_addr)
  );

  assign busy            = (r_state != ST_IDLE);
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err;
  assign first_fail_addr = r_ffa;
  assign m_chipselect    = w_wr || w_rd;
  assign m_write         = w_wr;
  assign m_address       = r_addr;
  assign m_writedata     = w_wr ? w_pat : '0;
  assign m_byteenable    = {(DATA_W/8){m_chipselect}};
  assign m_clken         = 1'b1;

endmodule

// File: tb/tb_ram_march_tester.sv
// Bench: two testers (read latency 1 and 2) on faultable RAM models,
// checked every cycle against a schedule-level behavioural model.
module tb_ram_march_tester;

  localparam int D = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        abort   = 1'b0;
  logic [31:0] seed    = '0;
  int          fault   = 0;

  logic        busy0, done0, pass0, cs0, wr0, ck0;
  logic [3:0]  err0, be0;
  logic [12:0] ad0, ffa0;
  logic [31:0] wd0, rd0;
  logic        busy1, done1, pass1, cs1, wr1, ck1;
  logic [15:0] err1;
  logic [3:0]  ad1, ffa1, be1;
  logic [31:0] wd1, rd1;

  ram_march_tester #(.ADDR_W(13), .DATA_W(32), .DEPTH(D),
                     .RD_LATENCY(1), .ERR_W(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .seed(seed), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_addr(ffa0), .m_address(ad0),
    .m_byteenable(be0), .m_chipselect(cs0), .m_write(wr0),
    .m_writedata(wd0), .m_clken(ck0), .m_readdata(rd0));

  ram_march_tester #(.ADDR_W(4), .DATA_W(32), .DEPTH(D),
                     .RD_LATENCY(2), .ERR_W(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .seed(seed), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_addr(ffa1), .m_address(ad1),
    .m_byteenable(be1), .m_chipselect(cs1), .m_write(wr1),
    .m_writedata(wd1), .m_clken(ck1), .m_readdata(rd1));

  // RAM models; fault 1 = bit3 of word 5 stuck at 0, 2 = every read bad
  logic [31:0] mem0 [D];
  logic [31:0] mem1 [D];
  logic [31:0] q0, q1a, q1b;

  function automatic logic [31:0] store(int a, logic [31:0] d);
    return (fault == 1 && a == 5) ? (d & ~32'h8) : d;
  endfunction

  function automatic logic [31:0] load(logic [31:0] d);
    return (fault == 2) ? (d ^ 32'h1) : d;
  endfunction

  always @(posedge clk) begin
    if (cs0 && wr0) mem0[ad0[3:0]] <= store(int'(ad0), wd0);
    if (cs0) q0 <= load(mem0[ad0[3:0]]);
    if (cs1 && wr1) mem1[ad1] <= store(int'(ad1), wd1);
    if (cs1) q1a <= load(mem1[ad1]);
    q1b <= q1a;
  end
  assign rd0 = q0;
  assign rd1 = q1b;

  // Uniform views of both DUTs for the compare process
  logic [1:0]  b_busy, b_done, b_pass, b_cs, b_wr, b_ck;
  logic [15:0] b_err [2];
  logic [12:0] b_ad [2], b_ffa [2];
  logic [31:0] b_wd [2];
  logic [3:0]  b_be [2];
  assign b_busy = {busy1, busy0};
  assign b_done = {done1, done0};
  assign b_pass = {pass1, pass0};
  assign b_cs   = {cs1, cs0};
  assign b_wr   = {wr1, wr0};
  assign b_ck   = {ck1, ck0};
  assign b_err[0] = {12'b0, err0};
  assign b_err[1] = err1;
  assign b_ad[0]  = ad0;
  assign b_ad[1]  = {9'b0, ad1};
  assign b_ffa[0] = ffa0;
  assign b_ffa[1] = {9'b0, ffa1};
  assign b_wd[0]  = wd0;
  assign b_wd[1]  = wd1;
  assign b_be[0]  = be0;
  assign b_be[1]  = be1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string nm, int d, logic [63:0] got,
                     logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %0h want %0h",
               nm, d, $time, got, exp);
    end
  endtask

  // Model: per DUT, the cycle index since start accept
  int          LAT [2]  = '{1, 2};
  int          EMAX [2] = '{15, 65535};
  bit          mb [2];
  int          cyc [2];
  bit          mdone [2];
  bit          mpass [2];
  int          merr [2];
  int          mff [2];
  logic [31:0] mseed [2];

  function automatic logic [31:0] pat(logic [31:0] s, int a, int k);
    return (s ^ 32'(a)) ^ ((k != 0) ? 32'hFFFF_FFFF : 32'h0);
  endfunction

  function automatic bit is_bad(logic [31:0] s, int a, int k);
    logic [31:0] p;
    p = pat(s, a, k);
    if (fault == 1) return (a == 5) && p[3];
    return fault == 2;
  endfunction

  // Which read (address a, pass k) is compared during cycle c
  function automatic bit cmp_slot(int c, int l, output int a,
                                  output int k);
    int seg;
    seg = 2 * D + l;
    a = 0;
    k = 0;
    if (c >= 2 * seg) return 1'b0;
    k = c / seg;
    a = (c % seg) - D - l;
    return (a >= 0) && (a < D);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      automatic int  a, k;
      automatic bit  hit;
      if (!reset_n) begin
        mb[d]    <= 1'b0;
        mdone[d] <= 1'b0;
        mpass[d] <= 1'b0;
        merr[d]  <= 0;
        mff[d]   <= 0;
      end else if (mb[d]) begin
        if (abort) begin
          mb[d]    <= 1'b0;
          mdone[d] <= 1'b1;
          mpass[d] <= 1'b0;
        end else begin
          hit = cmp_slot(cyc[d], LAT[d], a, k);
          if (hit && is_bad(mseed[d], a, k)) begin
            if (merr[d] < EMAX[d]) merr[d] <= merr[d] + 1;
            if (merr[d] == 0) mff[d] <= a;
          end
          if (cyc[d] == 2 * (2 * D + LAT[d])) begin
            mb[d]    <= 1'b0;
            mdone[d] <= 1'b1;
            mpass[d] <= (merr[d] == 0);
          end else begin
            cyc[d] <= cyc[d] + 1;
          end
        end
      end else if (start) begin
        mb[d]    <= 1'b1;
        cyc[d]   <= 0;
        mdone[d] <= 1'b0;
        mpass[d] <= 1'b0;
        merr[d]  <= 0;
        mff[d]   <= 0;
        mseed[d] <= seed;
      end
    end
  end

  bit chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        automatic int  seg = 2 * D + LAT[d];
        automatic int  r, k;
        automatic bit  ecs = 1'b0;
        automatic bit  ewr = 1'b0;
        automatic int  ea = 0;
        if (mb[d] && cyc[d] < 2 * seg) begin
          k = cyc[d] / seg;
          r = cyc[d] % seg;
          if (r < D) begin
            ecs = 1'b1; ewr = 1'b1; ea = r;
          end else if (r < 2 * D) begin
            ecs = 1'b1; ea = r - D;
          end
        end
        chk("busy", d, b_busy[d], mb[d]);
        chk("done", d, b_done[d], mdone[d]);
        if (mdone[d]) chk("pass", d, b_pass[d], mpass[d]);
        chk("err_count", d, b_err[d], merr[d]);
        chk("first_fail_addr", d, b_ffa[d], mff[d]);
        chk("chipselect", d, b_cs[d], ecs);
        chk("write", d, b_wr[d], ewr);
        chk("clken", d, b_ck[d], 1);
        if (ecs) begin
          chk("address", d, b_ad[d], ea);
          chk("byteenable", d, b_be[d], 4'hF);
        end
        if (ewr)
          chk("writedata", d, b_wd[d], pat(mseed[d], ea, k));
      end
    end
  end

  int lat0, lat1;

  // ab/st/rs: cycle index at which to pulse abort/start/reset (-1 none)
  task automatic run(logic [31:0] s, int f, int ab, int st, int rs);
    fault = f;
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seed  = $urandom;
    lat0 = -1;
    lat1 = -1;
    for (int i = 0; i < 300; i++) begin
      if (done0 && lat0 < 0) lat0 = i;
      if (done1 && lat1 < 0) lat1 = i;
      if (lat0 >= 0 && lat1 >= 0) break;
      if (rs >= 0 && i == rs + 1) begin
        chk("rst_busy", 0, {busy1, busy0}, 0);
        chk("rst_done", 0, {done1, done0}, 0);
        chk("rst_cs", 0, {cs1, wr1, cs0, wr0}, 0);
        chk("rst_addr", 0, {ad1, ad0}, 0);
        chk("rst_wdata", 0, {wd1, wd0}, 0);
        chk("rst_be", 0, {be1, be0}, 0);
        reset_n = 1'b1;
        break;
      end
      abort   = (i == ab);
      start   = (i == st);
      reset_n = (i != rs);
      @(negedge clk);
    end
    abort   = 1'b0;
    start   = 1'b0;
    reset_n = 1'b1;
    if (rs < 0) chk("finish_in_budget", 0, (lat0 >= 0 && lat1 >= 0), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("reset_outputs", 0,
        {busy0, done0, cs0, wr0, be0, err0, ad0, wd0}, 0);
    chk("reset_outputs", 1,
        {busy1, done1, cs1, wr1, be1, err1, ad1, wd1}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // good RAM: exact test length and clean pass
    run(32'hA5A5_0000, 0, -1, -1, -1);
    chk("latency", 0, lat0, 67);
    chk("latency", 1, lat1, 69);
    chk("good_pass", 0, {pass1, pass0, err0, err1}, {2'b11, 20'h0});

    // stuck-at bit3 of word 5, seed 0: only pass 1 sees it
    run(32'h0, 1, -1, -1, -1);
    chk("stuck_err", 0, err0, 1);
    chk("stuck_err", 1, err1, 1);
    chk("stuck_ffa", 0, {ffa1, ffa0}, {4'd5, 13'd5});
    chk("stuck_pass", 0, {pass1, pass0}, 0);

    // abort in RD pass 0 at address 7
    run(32'h0, 0, 23, -1, -1);
    chk("abort_latency", 0, lat0, 24);
    chk("abort_state", 0, {busy0, done0, pass0, cs0}, 4'b0100);
    chk("abort_state", 1, {busy1, done1, pass1, cs1}, 4'b0100);
    run($urandom, 0, -1, -1, -1);
    chk("after_abort_pass", 0, {pass1, pass0}, 2'b11);

    // seed 8 fails word 5 in pass 0; abort lands on its compare
    run(32'h8, 1, 22, -1, -1);
    chk("abort_drop_cmp", 0, err0, 0);
    chk("abort_drop_cmp", 1, err1, 0);
    run(32'h8, 1, 23, -1, -1);
    chk("abort_after_cmp", 0, {err0, ffa0}, {4'd1, 13'd5});
    chk("abort_inflight", 1, err1, 0);

    // abort pulsed while idle is ignored
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort", 0, {busy0, cs0}, 0);

    // every word corrupted: saturation on the 4-bit counter
    run($urandom, 2, -1, -1, -1);
    chk("sat_err", 0, err0, 4'hF);
    chk("full_err", 1, err1, 32);
    chk("sat_ffa", 0, {ffa1, ffa0}, 0);

    // start while busy ignored; reset mid-WR
    run($urandom, 0, -1, 10, -1);
    chk("busy_start_len", 0, {lat0, lat1}, {32'd67, 32'd69});
    run($urandom, 0, -1, -1, 5);

    // randomized runs
    for (int t = 0; t < 10; t++) begin
      automatic int f  = $urandom_range(0, 2);
      automatic int ab = ($urandom_range(0, 1) != 0) ?
                         int'($urandom_range(0, 75)) : -1;
      run($urandom, f, ab, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
